// File: rtl/dbg_sba_arbiter_pkg.sv
// rtl/dbg_sba_arbiter_pkg.sv - shared types and helpers for the SBA arbiter
// Holds the requester-index width helper, the default index type and the arbiter state enum.
package dbg_sba_arbiter_pkg;

    localparam int unsigned NumReqDefault = 2;

    // Index width for n requesters; never zero so a single requester still has a valid index.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned IdxWidth = idx_width(NumReqDefault);

    typedef logic [IdxWidth-1:0] req_idx_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

endpackage

// File: rtl/dbg_sba_id_fifo.sv
// rtl/dbg_sba_id_fifo.sv - in-order FIFO of requester indices for outstanding transactions
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/data_i enqueue;
// pop_i dequeue; head_o oldest entry; full_o/empty_o registered occupancy flags.
module dbg_sba_id_fifo
    import dbg_sba_arbiter_pkg::*;
#(
    parameter int unsigned Depth  = 4,
    parameter type         data_t = req_idx_t
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  push_i,
    input  data_t data_i,
    input  logic  pop_i,
    output data_t head_o,
    output logic  full_o,
    output logic  empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    data_t mem_q [Depth];
    data_t mem_d [Depth];
    ptr_t  wr_ptr_q, wr_ptr_d;
    ptr_t  rd_ptr_q, rd_ptr_d;
    cnt_t  count_q, count_d;
    logic  push, pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == cnt_t'(Depth));
    assign empty_o = (count_q == '0);
    assign push    = push_i & ~full_o;
    assign pop     = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/dbg_sba_arbiter.sv
// rtl/dbg_sba_arbiter.sv - round-robin arbiter sharing one SBA memory port between requesters
// Ports: req_i/addr_i/we_i/wdata_i/be_i + gnt_o requester side; rvalid_o/rdata_o/err_o responses;
// mem_* downstream memory port; busy_o transactions outstanding; unexp_rsp_o sticky stray-response flag.
module dbg_sba_arbiter
    import dbg_sba_arbiter_pkg::*;
#(
    parameter int unsigned NumReq         = NumReqDefault,
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NumReq-1:0]                    req_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]     addr_i,
    input  logic [NumReq-1:0]                    we_i,
    input  logic [NumReq-1:0][DataWidth-1:0]     wdata_i,
    input  logic [NumReq-1:0][DataWidth/8-1:0]   be_i,
    output logic [NumReq-1:0]                    gnt_o,
    output logic [NumReq-1:0]                    rvalid_o,
    output logic [DataWidth-1:0]                 rdata_o,
    output logic                                 err_o,
    output logic                                 mem_req_o,
    output logic [AddrWidth-1:0]                 mem_addr_o,
    output logic                                 mem_we_o,
    output logic [DataWidth-1:0]                 mem_wdata_o,
    output logic [DataWidth/8-1:0]               mem_be_o,
    input  logic                                 mem_gnt_i,
    input  logic                                 mem_rvalid_i,
    input  logic [DataWidth-1:0]                 mem_rdata_i,
    input  logic                                 mem_err_i,
    output logic                                 busy_o,
    output logic                                 unexp_rsp_o
);

    localparam int unsigned IdxW = idx_width(NumReq);
    typedef logic [IdxW-1:0] idx_t;

    arb_state_e state_q, state_d;
    idx_t       rr_ptr_q, rr_ptr_d;
    idx_t       lock_idx_q, lock_idx_d;
    idx_t       pick_idx, sel, head;
    logic       unexp_q, unexp_d;
    logic       fifo_full, fifo_empty;
    logic       xfer, pop;

    function automatic idx_t idx_inc(input idx_t i);
        return (i == idx_t'(NumReq - 1)) ? '0 : i + 1'b1;
    endfunction

    // Cyclic search starting at rr_ptr; falls back to rr_ptr when nobody requests
    // (payload is don't-care then since mem_req_o is low).
    always_comb begin
        logic found;
        idx_t cand;
        pick_idx = rr_ptr_q;
        found    = 1'b0;
        cand     = rr_ptr_q;
        for (int i = 0; i < int'(NumReq); i++) begin
            if (!found && req_i[cand]) begin
                found    = 1'b1;
                pick_idx = cand;
            end
            cand = idx_inc(cand);
        end
    end

    // A stalled request keeps its slot so a late-arriving requester cannot swap the payload.
    assign sel = (state_q == ARB_LOCKED) ? lock_idx_q : pick_idx;

    // Full gating uses the registered flag only; a same-cycle pop does not free a slot.
    assign mem_req_o   = (|req_i) & ~fifo_full;
    assign xfer        = mem_req_o & mem_gnt_i;
    assign mem_addr_o  = addr_i[sel];
    assign mem_we_o    = we_i[sel];
    assign mem_wdata_o = wdata_i[sel];
    assign mem_be_o    = be_i[sel];

    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_o      = '0;
        if (xfer) begin
            gnt_o[sel] = 1'b1;
            rr_ptr_d   = idx_inc(sel);
        end
        case (state_q)
            ARB_IDLE: begin
                if (mem_req_o && !mem_gnt_i) begin
                    state_d    = ARB_LOCKED;
                    lock_idx_d = sel;
                end
            end
            ARB_LOCKED: begin
                if (xfer) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    dbg_sba_id_fifo #(
        .Depth  (MaxOutstanding),
        .data_t (idx_t)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (xfer),
        .data_i  (sel),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Responses arriving with nothing outstanding are dropped and only flagged.
    assign pop     = mem_rvalid_i & ~fifo_empty;
    assign unexp_d = unexp_q | (mem_rvalid_i & fifo_empty);

    always_comb begin
        rvalid_o = '0;
        if (pop) begin
            rvalid_o[head] = 1'b1;
        end
    end

    assign rdata_o     = mem_rdata_i;
    assign err_o       = mem_err_i & pop;
    assign busy_o      = ~fifo_empty;
    assign unexp_rsp_o = unexp_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ARB_IDLE;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
            unexp_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
            unexp_q    <= unexp_d;
        end
    end

endmodule

// File: doc/dbg_sba_arbiter.md
# dbg_sba_arbiter

Round-robin arbiter that shares the debug subsystem's single memory-style system-bus-access port, the one feeding `axi_from_mem`, between `NumReq` requesters, such as the debug module SBA master plus a trace or boot-loader DMA. It forwards one granted request at a time downstream. It tracks the requester index of every outstanding transaction in an in-order ID FIFO and routes each in-order response back to its originator. It sits between the requesters and `axi_from_mem` inside `debug_subsystem`.

## Interface
Parameters:
- NumReq, 2, number of requesters (≥1)
- AddrWidth, 64, address width
- DataWidth, 64, data width; byte-enable width = DataWidth/8
- MaxOutstanding, 4, maximum in-flight transactions (≥1); sets ID FIFO depth

Ports (reset rst_ni, asynchronous, active-low; clock clk_i):
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- req_i  in  NumReq  per-requester request
- addr_i  in  NumReq×AddrWidth  request address
- we_i  in  NumReq  write enable
- wdata_i  in  NumReq×DataWidth  write data
- be_i  in  NumReq×DataWidth/8  byte enables
- gnt_o  out  NumReq  grant, one-hot or zero
- rvalid_o  out  NumReq  response valid, one-hot or zero
- rdata_o  out  DataWidth  response data, shared by all requesters
- err_o  out  1  response error, qualified by rvalid_o
- mem_req_o  out  1  downstream request
- mem_addr_o / mem_we_o / mem_wdata_o / mem_be_o  out  AddrWidth / 1 / DataWidth / DataWidth/8  downstream payload
- mem_gnt_i  in  1  downstream grant
- mem_rvalid_i  in  1  downstream response valid; responses return in order
- mem_rdata_i  in  DataWidth  downstream response data
- mem_err_i  in  1  downstream response error
- busy_o  out  1  ID FIFO non-empty
- unexp_rsp_o  out  1  sticky flag: response received with no outstanding transaction

## Operation
Handshakes:
- Requester handshake is req/gnt. The requester holds req_i and its payload stable until gnt_o. A transfer occurs on the cycle with req_i=1 and gnt_o=1.
- Downstream transfer occurs when mem_req_o=1 and mem_gnt_i=1.

Arbitration:
- The arbiter has two states, IDLE and LOCKED.
- IDLE: select the first asserted req_i at or after rr_ptr, searching cyclically.
- mem_req_o = (any req_i) & !fifo_full.
- Payload outputs are a combinational mux of the selected requester.
- If mem_req_o=1 and mem_gnt_i=0, latch the selected index into lock_idx and enter LOCKED.
- LOCKED: the selection is forced to lock_idx, so other requesters cannot preempt. On the downstream transfer, return to IDLE.
- gnt_o[sel] = mem_req_o & mem_gnt_i. All other bits are 0.
- On each transfer: rr_ptr ← (sel+1) mod NumReq, wrapping from NumReq−1 to 0. Push sel into the ID FIFO.

Response routing:
- On mem_rvalid_i with FIFO non-empty: rvalid_o[head]=1, rdata_o=mem_rdata_i, err_o=mem_err_i, pop the FIFO.
- On mem_rvalid_i with FIFO empty: drop the response, rvalid_o stays all zeros, set unexp_rsp_o. unexp_rsp_o is cleared only by reset.

FIFO boundary conditions:
- Full: mem_req_o is held low even if requests are pending. The gating uses the registered full flag, with no same-cycle pop bypass.
- Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- A push when empty and a later pop return the pushed index.

Reset:
- Reset mid-transaction clears the FIFO, rr_ptr, lock and unexp_rsp_o.
- Responses for transactions issued before reset are treated as unexpected.

## Timing
- Request path is combinational: req_i→mem_req_o and mem_gnt_i→gnt_o with zero latency.
- Response path is combinational: mem_rvalid_i→rvalid_o with zero latency.
- The ID FIFO and rr_ptr update on the clock edge of the transfer. The earliest response to a transaction can be consumed in the cycle after its grant.
- Reset values:
  - Registers: rr_ptr=0, state=IDLE, FIFO empty, unexp_rsp_o=0.
  - Outputs (combinational, follow inputs): gnt_o=0, rvalid_o=0, mem_req_o=0 while all req_i=0, busy_o=0.
- Throughput: one transaction per cycle while mem_gnt_i=1 and the FIFO is not full.

## Structure
- Shared package `dbg_sba_arbiter_pkg` holds:
  - `IdxWidth = $clog2(NumReq)`, minimum 1, and the `req_idx_t` typedef.
  - State enum `arb_state_e {ARB_IDLE, ARB_LOCKED}`.
- One sub-module, `dbg_sba_id_fifo`: a synchronous FIFO of `req_idx_t`, depth MaxOutstanding, exposing full/empty/push/pop/head.
- The round-robin pick, lock register and payload mux are implemented inline.

## Test plan
- Single requester: req_i=01, addr=0x1000, mem_gnt_i=1 → gnt_o=01 the same cycle. The response with rdata=0xDEAD_BEEF, 3 cycles later, gives rvalid_o=01, rdata_o=0xDEAD_BEEF.
- Fairness: req_i=11 held, mem_gnt_i=1 every cycle → gnt_o alternates 01,10,01,10. rr_ptr wraps from 1 to 0.
- Lock: requester 0 selected, mem_gnt_i=0 for 3 cycles, then req_i[1] rises → mem_addr_o stays at requester 0's address until the grant. gnt_o[1] stays 0 during the stall.
- Full: 4 grants with no responses (MaxOutstanding=4) → mem_req_o=0 while req_i=01. One response → mem_req_o=1 the next cycle.
- Ordering: grants in order 1,0,1 → the next three responses assert rvalid_o=10,01,10 with matching data and err_o=1 on the second.
- Unexpected response: mem_rvalid_i=1 with busy_o=0 → rvalid_o=00, unexp_rsp_o=1 and held. An async reset mid-burst clears busy_o and unexp_rsp_o immediately.
